// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: IF/ID payload, fetch FSM states and the bubble encoding.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
    logic            misalign;
  } if_id_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } fetch_state_e;

  function automatic if_id_t make_bubble(input logic [XLEN-1:0] nop);
    if_id_t b;
    b.valid    = 1'b0;
    b.pc       = '0;
    b.pc4      = '0;
    b.inst     = nop;
    b.misalign = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush (or reset) loads a bubble, otherwise loads d_i when enabled.
module if_id_reg
  import rv32i_pkg::*;
#(
  parameter logic [31:0] NOP_INST = rv32i_pkg::NOP_INST
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t if_id_q;

  // Flush outranks enable so a redirect squashes the entry even under stall.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      if_id_q <= make_bubble(NOP_INST);
    end else if (en_i) begin
      if_id_q <= d_i;
    end
  end

  assign q_o = if_id_q;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC selection, misaligned-fetch trap FSM
// and the IF/ID pipeline register.
module if_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_inst_o,
  output logic        if_id_misalign_o,
  output logic        fetch_halted_o
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  fetch_state_e state_q, state_d;
  if_id_t       if_id_d, if_id_q;
  logic         if_id_en;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    if_id_d  = make_bubble(NOP_INST);
    if_id_en = !stall_i;
    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      state_d = RUN;
    end else if (!stall_i) begin
      unique case (state_q)
        RUN: begin
          if_id_d.valid = 1'b1;
          if_id_d.pc    = pc_q;
          if_id_d.pc4   = pc_plus4;
          // A misaligned PC becomes an exception entry and freezes fetch until redirected.
          if (pc_q[1:0] != 2'b00) begin
            if_id_d.misalign = 1'b1;
            state_d          = TRAP;
          end else begin
            if_id_d.inst = imem_inst_i;
            pc_d         = pc_plus4;
          end
        end
        TRAP: begin
          if_id_d = make_bubble(NOP_INST);
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (if_id_en),
    .flush_i (redirect_i),
    .d_i     (if_id_d),
    .q_o     (if_id_q)
  );

  assign imem_addr_o      = pc_q;
  assign if_id_valid_o    = if_id_q.valid;
  assign if_id_pc_o       = if_id_q.pc;
  assign if_id_pc4_o      = if_id_q.pc4;
  assign if_id_inst_o     = if_id_q.inst;
  assign if_id_misalign_o = if_id_q.misalign;
  assign fetch_halted_o   = (state_q == TRAP);

endmodule
